// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Control-field encodings shared by the core pipeline stages. Every *_ctrl
// field has a no-operation encoding. The pc_ctrl NOP is "increment" (PC_INC),
// which is deliberately not the all-zero value.
// ---------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_AND  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SRA  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        LSU_NOP = 3'd0,
        LSU_LB  = 3'd1,
        LSU_LH  = 3'd2,
        LSU_LW  = 3'd3,
        LSU_SB  = 3'd4,
        LSU_SH  = 3'd5,
        LSU_SW  = 3'd6
    } lsu_ctrl_e;

    typedef enum logic [1:0] {
        CSR_NOP = 2'd0,
        CSR_RW  = 2'd1,
        CSR_RS  = 2'd2,
        CSR_RC  = 2'd3
    } csr_ctrl_e;

    typedef enum logic [1:0] {
        PC_STALL  = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_ctrl_e;

    typedef enum logic [1:0] {
        WB_NOP = 2'd0,
        WB_ALU = 2'd1,
        WB_LSU = 2'd2,
        WB_CSR = 2'd3
    } wb_ctrl_e;

endpackage

// File: rtl/id2exe_pkg.sv
// ---------------------------------------------------------------------------
// id2exe_pkg
// Payload type carried from Decode to Execute, its NOP value (driven toward
// EXE whenever the buffer is empty), and the buffer depth limits.
// ---------------------------------------------------------------------------
package id2exe_pkg;

    import core_pkg::*;

    localparam int unsigned ID2EXE_DEPTH_MAX = 8;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] op3;
        alu_ctrl_e   alu_ctrl;
        lsu_ctrl_e   lsu_ctrl;
        csr_ctrl_e   csr_ctrl;
        pc_ctrl_e    pc_ctrl;
        wb_ctrl_e    wb_ctrl;
    } id2exe_t;

    localparam id2exe_t ID2EXE_NOP = '{
        rd:       5'd0,
        pc:       32'd0,
        op1:      32'd0,
        op2:      32'd0,
        op3:      32'd0,
        alu_ctrl: ALU_NOP,
        lsu_ctrl: LSU_NOP,
        csr_ctrl: CSR_NOP,
        pc_ctrl:  PC_INC,
        wb_ctrl:  WB_NOP
    };

    // Power-of-two depths only: the queue pointers rely on natural binary wrap.
    function automatic bit id2exe_depth_legal(input int unsigned depth);
        return (depth == 1) || (depth == 2) || (depth == 4) ||
               (depth == ID2EXE_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/id2exe_buffer.sv
// ---------------------------------------------------------------------------
// id2exe_buffer
// Elastic valid/ready buffer between Decode (ID) and Execute (EXE).
//   DEPTH == 1 : register mode, in_ready_o is combinational from out_ready_i
//                so a push and a pop in the same cycle give full throughput.
//   DEPTH >= 2 : circular queue with a registered in_ready_o (no path from
//                out_ready_i to in_ready_o). When full, a pop does not admit a
//                push in the same cycle.
// flush_i discards all entries and any push/pop of that cycle.
// out_data_o is ID2EXE_NOP whenever out_valid_o is low.
//
// Ports
//   clk_i        core clock, rising edge
//   rstn_i       asynchronous active-low reset
//   flush_i      synchronous flush
//   in_valid_i   / in_ready_o  / in_data_i    : ID side handshake + payload
//   out_valid_o  / out_ready_i / out_data_o   : EXE side handshake + payload
//   count_o      current occupancy
// ---------------------------------------------------------------------------
module id2exe_buffer
    import id2exe_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  id2exe_t                      in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output id2exe_t                      out_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    if (!id2exe_depth_legal(DEPTH)) begin : g_depth_check
        $error("id2exe_buffer: DEPTH=%0d is not one of 1, 2, 4, 8", DEPTH);
    end

    id2exe_t head;

    assign out_data_o = out_valid_o ? head : ID2EXE_NOP;

    if (DEPTH == 1) begin : g_register
        logic    valid_q;
        id2exe_t data_q;
        logic    push;

        assign in_ready_o  = !valid_q | out_ready_i;
        assign push        = in_valid_i & in_ready_o;
        assign out_valid_o = valid_q;
        assign count_o     = valid_q;
        assign head        = data_q;

        // A push wins over a pop: the slot is refilled in the same edge.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                valid_q <= 1'b0;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end else if (push) begin
                valid_q <= 1'b1;
            end else if (out_ready_i) begin
                valid_q <= 1'b0;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push && !flush_i) begin
                data_q <= in_data_i;
            end
        end

    end else begin : g_queue
        localparam int unsigned PW = $clog2(DEPTH);

        id2exe_t          mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q;
        logic [PW-1:0]    wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q;
        logic [PW-1:0]    rd_ptr_d;
        logic [CW-1:0]    count_q;
        logic [CW-1:0]    count_d;
        logic             in_ready_q;
        logic             in_ready_d;
        logic             push;
        logic             pop;

        assign push        = in_valid_i & in_ready_q;
        assign pop         = (count_q != '0) & out_ready_i;
        assign in_ready_o  = in_ready_q;
        assign out_valid_o = (count_q != '0);
        assign count_o     = count_q;
        assign head        = mem_q[rd_ptr_q];

        // Pointers wrap naturally because DEPTH is a power of two.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
            // Registered ready is computed from the next occupancy, so a pop
            // at full only reopens the input after the edge.
            in_ready_d = (count_d < CW'(DEPTH));
        end

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                in_ready_q <= 1'b1;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                in_ready_q <= in_ready_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push && !flush_i) begin
                mem_q[wr_ptr_q] <= in_data_i;
            end
        end
    end

endmodule

// File: tb/tb_id2exe_buffer.sv
module tb_id2exe_buffer;

    import core_pkg::*;
    import id2exe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rstn;
    logic    flush;
    logic    in_valid  [4];
    id2exe_t in_data   [4];
    logic    out_ready [4];
    logic    in_ready  [4];
    logic    out_valid [4];
    id2exe_t out_data  [4];
    logic [0:0] cnt1;
    logic [1:0] cnt2;
    logic [2:0] cnt4;
    logic [3:0] cnt8;

    int n_checks = 0;
    int n_fail   = 0;

    id2exe_buffer #(.DEPTH(1)) u_d1 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
        .count_o(cnt1));
    id2exe_buffer #(.DEPTH(2)) u_d2 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
        .count_o(cnt2));
    id2exe_buffer #(.DEPTH(4)) u_d4 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_data_i(in_data[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(out_data[2]),
        .count_o(cnt4));
    id2exe_buffer #(.DEPTH(8)) u_d8 (
        .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
        .in_valid_i(in_valid[3]), .in_ready_o(in_ready[3]), .in_data_i(in_data[3]),
        .out_valid_o(out_valid[3]), .out_ready_i(out_ready[3]), .out_data_o(out_data[3]),
        .count_o(cnt8));

    function automatic id2exe_t mk(input logic [31:0] pc);
        id2exe_t p;
        p.rd       = pc[6:2];
        p.pc       = pc;
        p.op1      = pc ^ 32'hA5A5_0000;
        p.op2      = ~pc;
        p.op3      = pc + 32'd3;
        p.alu_ctrl = ALU_ADD;
        p.lsu_ctrl = LSU_LW;
        p.csr_ctrl = CSR_RS;
        p.pc_ctrl  = PC_BRANCH;
        p.wb_ctrl  = WB_ALU;
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        in_valid[1]  = 1'b1;
        in_data[1]   = mk(32'h100);
        out_ready[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid[1]); end
        n_checks++; if (cnt2 !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt2); end
        n_checks++; if (in_ready[1] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready[1]); end
        n_checks++; if (out_data[1] !== ID2EXE_NOP) begin n_fail++; $display("FAIL reset_data: got %h want %h", out_data[1], ID2EXE_NOP); end
        n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready_d1: got %b want 1", in_ready[0]); end
        n_checks++; if (out_data[0] !== ID2EXE_NOP) begin n_fail++; $display("FAIL reset_data_d1: got %h want %h", out_data[0], ID2EXE_NOP); end
        @(negedge clk);
        rstn = 1'b1;
        step();
        in_valid[1] = 1'b0;
        n_checks++; if (out_valid[1] !== 1'b1) begin n_fail++; $display("FAIL first_push_valid: got %b want 1", out_valid[1]); end
        n_checks++; if (out_data[1] !== mk(32'h100)) begin n_fail++; $display("FAIL first_push_data: got %h want %h", out_data[1], mk(32'h100)); end
        n_checks++; if (cnt2 !== 2'd1) begin n_fail++; $display("FAIL first_push_count: got %0d want 1", cnt2); end
        out_ready[1] = 1'b1;
        step();
        out_ready[1] = 1'b0;
        n_checks++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL first_pop_valid: got %b want 0", out_valid[1]); end
        n_checks++; if (out_data[1] !== ID2EXE_NOP) begin n_fail++; $display("FAIL first_pop_nop: got %h want %h", out_data[1], ID2EXE_NOP); end
    endtask

    task automatic test_backpressure();
        out_ready[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[2] = 1'b1;
            in_data[2]  = mk(32'(4 * i));
            n_checks++; if (in_ready[2] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_before_push%0d: got %b want 1", i, in_ready[2]); end
            step();
        end
        in_valid[2] = 1'b0;
        n_checks++; if (cnt4 !== 3'd4) begin n_fail++; $display("FAIL bp_full_count: got %0d want 4", cnt4); end
        n_checks++; if (in_ready[2] !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", in_ready[2]); end
        out_ready[2] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (out_valid[2] !== 1'b1) begin n_fail++; $display("FAIL bp_pop_valid%0d: got %b want 1", i, out_valid[2]); end
            n_checks++; if (out_data[2] !== mk(32'(4 * i))) begin n_fail++; $display("FAIL bp_pop_data%0d: got pc %h want pc %h", i, out_data[2].pc, 4 * i); end
            step();
            if (i == 0) begin
                n_checks++; if (in_ready[2] !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", in_ready[2]); end
            end
        end
        out_ready[2] = 1'b0;
        n_checks++; if (out_valid[2] !== 1'b0 || cnt4 !== 3'd0) begin n_fail++; $display("FAIL bp_drained: valid %b count %0d want 0 0", out_valid[2], cnt4); end
        n_checks++; if (out_data[2] !== ID2EXE_NOP) begin n_fail++; $display("FAIL bp_drained_nop: got %h want %h", out_data[2], ID2EXE_NOP); end
    endtask

    task automatic test_streaming();
        int n_out = 0;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 17; c++) begin
            in_valid[0] = (c < 16);
            in_data[0]  = mk(32'h200 + 32'(4 * c));
            if (c < 16) begin
                n_checks++; if (in_ready[0] !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d: got %b want 1", c, in_ready[0]); end
            end
            step();
            n_checks++; if (out_valid[0] !== (c < 16)) begin n_fail++; $display("FAIL stream_valid%0d: got %b want %b", c, out_valid[0], (c < 16)); end
            n_checks++; if (cnt1 !== 1'((c < 16))) begin n_fail++; $display("FAIL stream_count%0d: got %0d want %0d", c, cnt1, (c < 16)); end
            if (out_valid[0] === 1'b1) begin
                n_checks++; if (out_data[0] !== mk(32'h200 + 32'(4 * n_out))) begin n_fail++; $display("FAIL stream_data%0d: got pc %h want pc %h", n_out, out_data[0].pc, 32'h200 + 32'(4 * n_out)); end
                n_out++;
            end
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        n_checks++; if (n_out !== 16) begin n_fail++; $display("FAIL stream_total: got %0d outputs want 16", n_out); end
    endtask

    task automatic test_wrap();
        logic [1:0] pat [16];
        id2exe_t    q [$];
        int m = 0;
        int k = 0;
        int n_pop = 0;
        bit push;
        bit pop;
        pat = '{2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b01,
                2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11};
        for (int i = 0; i < 20; i++) begin
            logic [1:0] p;
            p = (i < 16) ? pat[i] : 2'b01;
            in_valid[1]  = p[1];
            in_data[1]   = mk(32'h300 + 32'(4 * k));
            out_ready[1] = p[0];
            n_checks++; if (in_ready[1] !== (m < 2)) begin n_fail++; $display("FAIL wrap_ready%0d: got %b want %b", i, in_ready[1], (m < 2)); end
            n_checks++; if (out_valid[1] !== (m != 0)) begin n_fail++; $display("FAIL wrap_valid%0d: got %b want %b", i, out_valid[1], (m != 0)); end
            n_checks++; if (cnt2 !== 2'(m)) begin n_fail++; $display("FAIL wrap_count%0d: got %0d want %0d", i, cnt2, m); end
            if (m != 0) begin
                n_checks++; if (out_data[1] !== q[0]) begin n_fail++; $display("FAIL wrap_data%0d: got pc %h want pc %h", i, out_data[1].pc, q[0].pc); end
            end
            push = p[1] && (m < 2);
            pop  = p[0] && (m != 0);
            if (pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (push) begin
                q.push_back(mk(32'h300 + 32'(4 * k)));
                k++;
            end
            m = m + int'(push) - int'(pop);
            step();
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b0;
        n_checks++; if (cnt2 !== 2'd0 || out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL wrap_end_empty: count %0d valid %b want 0 0", cnt2, out_valid[1]); end
        n_checks++; if (n_pop !== k || k !== 10) begin n_fail++; $display("FAIL wrap_totals: popped %0d pushed %0d want 10 10", n_pop, k); end
    endtask

    task automatic test_flush();
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[2] = 1'b1;
            in_data[2]  = mk(32'h10 + 32'(4 * i));
            step();
        end
        n_checks++; if (cnt4 !== 3'd3) begin n_fail++; $display("FAIL flush_prefill: got %0d want 3", cnt4); end
        flush        = 1'b1;
        in_valid[2]  = 1'b1;
        in_data[2]   = mk(32'h40);
        out_ready[2] = 1'b1;
        step();
        flush       = 1'b0;
        in_valid[2] = 1'b0;
        n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", cnt4); end
        n_checks++; if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid[2]); end
        n_checks++; if (in_ready[2] !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", in_ready[2]); end
        n_checks++; if (out_data[2] !== ID2EXE_NOP) begin n_fail++; $display("FAIL flush_nop: got %h want %h", out_data[2], ID2EXE_NOP); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid[2] !== 1'b0) begin n_fail++; $display("FAIL flush_ghost%0d: got valid %b pc %h want 0", i, out_valid[2], out_data[2].pc); end
        end
        out_ready[2] = 1'b0;
        in_valid[2]  = 1'b1;
        in_data[2]   = mk(32'h44);
        step();
        in_valid[2] = 1'b0;
        n_checks++; if (out_valid[2] !== 1'b1 || out_data[2] !== mk(32'h44)) begin n_fail++; $display("FAIL flush_resume: valid %b pc %h want 1 44", out_valid[2], out_data[2].pc); end
        out_ready[2] = 1'b1;
        step();
        out_ready[2] = 1'b0;
        n_checks++; if (cnt4 !== 3'd0) begin n_fail++; $display("FAIL flush_resume_drain: got %0d want 0", cnt4); end
    endtask

    task automatic test_async_reset();
        out_ready[3] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[3] = 1'b1;
            in_data[3]  = mk(32'h500 + 32'(4 * i));
            step();
        end
        in_valid[3] = 1'b0;
        n_checks++; if (cnt8 !== 4'd5 || out_valid[3] !== 1'b1) begin n_fail++; $display("FAIL areset_prefill: count %0d valid %b want 5 1", cnt8, out_valid[3]); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (out_valid[3] !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid[3]); end
        n_checks++; if (cnt8 !== 4'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", cnt8); end
        n_checks++; if (out_data[3] !== ID2EXE_NOP) begin n_fail++; $display("FAIL areset_nop: got %h want %h", out_data[3], ID2EXE_NOP); end
        n_checks++; if (in_ready[3] !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", in_ready[3]); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid[3] = 1'b1;
            in_data[3]  = mk(32'h580 + 32'(4 * i));
            step();
        end
        n_checks++; if (cnt8 !== 4'd8 || in_ready[3] !== 1'b0) begin n_fail++; $display("FAIL d8_full: count %0d ready %b want 8 0", cnt8, in_ready[3]); end
        in_data[3]   = mk(32'h600);
        out_ready[3] = 1'b1;
        step();
        n_checks++; if (cnt8 !== 4'd7 || in_ready[3] !== 1'b1) begin n_fail++; $display("FAIL d8_pop_at_full: count %0d ready %b want 7 1", cnt8, in_ready[3]); end
        n_checks++; if (out_data[3] !== mk(32'h584)) begin n_fail++; $display("FAIL d8_head_after_pop: got pc %h want pc 584", out_data[3].pc); end
        step();
        in_valid[3]  = 1'b0;
        out_ready[3] = 1'b0;
        n_checks++; if (cnt8 !== 4'd7 || out_data[3] !== mk(32'h588)) begin n_fail++; $display("FAIL d8_push_pop: count %0d pc %h want 7 588", cnt8, out_data[3].pc); end
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = ID2EXE_NOP;
            out_ready[i] = 1'b0;
        end
        test_reset();
        test_backpressure();
        test_streaming();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
